// File: rtl/cla_seq_pkg.sv
// Shared types for the sequential CLA adder.
// State encoding and idx sizing helper.
package cla_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int NIB_W(input int width);
      int n;
      n = $clog2(width / 4);
      return (n < 1) ? 1 : n;
   endfunction

endpackage

// File: rtl/cla.sv
// 4-bit carry-lookahead adder.
// Purely combinational; carries from generate/propagate.
module cla (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       carry
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a & b;
   assign p = a ^ b;

   // lookahead carries, flattened per bit
   always_comb begin
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0])
           | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1])
           | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2])
           | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
   end

   assign sum   = p ^ c[3:0];
   assign carry = c[4];

endmodule

// File: rtl/cla_seq_adder.sv
// Wide add/sub, one nibble per clock through a
// single shared 4-bit CLA, LSB nibble first.
module cla_seq_adder
   import cla_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             busy
);

   localparam int NIB = WIDTH / 4;
   localparam int NW  = NIB_W(WIDTH);
   localparam logic [NW-1:0] LAST = NW'(NIB - 1);

   if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
      $error("cla_seq_adder: WIDTH must be 4*n and >= 8");
   end

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] sum_r;
   logic             c_r;
   logic [NW-1:0]    idx;
   logic [3:0]       na;
   logic [3:0]       nb;
   logic [3:0]       ns;
   logic             nc;
   logic             accept;

   assign na = a_r[4*idx +: 4];
   assign nb = b_r[4*idx +: 4];

   cla u_cla (
      .a     (na),
      .b     (nb),
      .cin   (c_r),
      .sum   (ns),
      .carry (nc)
   );

   assign accept = (state == IDLE) & in_valid;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // next state and handshake decode
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = RUN;
         end
         RUN: begin
            if (idx == LAST) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // operand latch and per-nibble accumulate
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r   <= '0;
         b_r   <= '0;
         sum_r <= '0;
         c_r   <= 1'b0;
         idx   <= '0;
      end else if (accept) begin
         a_r <= in_a;
         b_r <= in_sub ? ~in_b : in_b;
         c_r <= in_sub ? 1'b1 : in_cin;
         idx <= '0;
      end else if (state == RUN) begin
         sum_r[4*idx +: 4] <= ns;
         c_r <= nc;
         idx <= idx + 1'b1;
      end
   end

   assign out_sum  = sum_r;
   assign out_cout = c_r;
   assign out_ovf  =
      (a_r[WIDTH-1] == b_r[WIDTH-1]) &
      (sum_r[WIDTH-1] != a_r[WIDTH-1]);

endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder, WIDTH=16.
// Expected results from plain integer arithmetic.
module tb_cla_seq_adder;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        in_cin;
   logic        in_sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_sum;
   logic        out_cout;
   logic        out_ovf;
   logic        busy;

   cla_seq_adder #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
      int          acc;
   } exp_t;

   exp_t q[$];
   int   n_chk;
   int   n_fail;
   int   cyc;
   int   rdy_mode;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   task automatic chk(input string nm,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h expected %0h",
                  nm, got, exp);
      end
   endtask

   task automatic fail(input string nm);
      n_chk  = n_chk + 1;
      n_fail = n_fail + 1;
      $display("FAIL %s: bound expired", nm);
   endtask

   function automatic exp_t model(
      input logic [15:0] a, input logic [15:0] b,
      input logic cin, input logic sub);
      exp_t e;
      int   ua, ub, sa, sb, r, u;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (!sub) begin
         u = ua + ub + int'(cin);
         r = sa + sb + int'(cin);
         e.cout = (u > 65535);
      end else begin
         u = ua - ub;
         r = sa - sb;
         e.cout = (ua >= ub);
      end
      e.sum = 16'(u & 65535);
      e.ovf = (r > 32767) || (r < -32768);
      e.acc = 0;
      return e;
   endfunction

   // out_ready driver: 0 hold low, 1 hold high, 2 random
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // scoreboard push on every accepted request
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && in_valid && in_ready) begin
            e = model(in_a, in_b, in_cin, in_sub);
            e.acc = cyc + 1;
            q.push_back(e);
         end
      end
   end

   // monitor: latency on rise, compare on handshake
   initial begin
      logic pv;
      exp_t e;
      pv = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid) begin
            if (q.size() == 0) begin
               chk("stale_out_valid", 32'(out_valid), 0);
            end else begin
               if (!pv)
                  chk("latency", cyc, q[0].acc + 4);
               if (out_ready) begin
                  e = q.pop_front();
                  chk("sum", 32'(out_sum), 32'(e.sum));
                  chk("cout", 32'(out_cout), 32'(e.cout));
                  chk("ovf", 32'(out_ovf), 32'(e.ovf));
               end
            end
         end
         pv = rst_n & out_valid;
      end
   end

   task automatic issue(input logic [15:0] a,
                        input logic [15:0] b,
                        input logic cin,
                        input logic sub);
      int t;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      in_cin = cin;
      in_sub = sub;
      t = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         t = t + 1;
         if (t > 40) begin
            fail("issue_wait");
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input int bound);
      int t;
      t = 0;
      while (q.size() != 0) begin
         @(negedge clk);
         t = t + 1;
         if (t > bound) begin
            fail("drain");
            q.delete();
            break;
         end
      end
   endtask

   logic [15:0] da [8];
   logic [15:0] db [8];
   logic        dc [8];
   logic        ds [8];

   initial begin
      int t;
      logic [15:0] pick [5];
      logic [15:0] ra, rb;
      n_chk = 0;
      n_fail = 0;
      rdy_mode = 1;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      in_cin = 1'b0;
      in_sub = 1'b0;

      da[0] = 16'h00FF; db[0] = 16'h0001; dc[0] = 0; ds[0] = 0;
      da[1] = 16'hFFFF; db[1] = 16'h0001; dc[1] = 0; ds[1] = 0;
      da[2] = 16'h1234; db[2] = 16'h0000; dc[2] = 1; ds[2] = 0;
      da[3] = 16'h0005; db[3] = 16'h0007; dc[3] = 0; ds[3] = 1;
      da[4] = 16'h0007; db[4] = 16'h0005; dc[4] = 1; ds[4] = 1;
      da[5] = 16'h7FFF; db[5] = 16'h0001; dc[5] = 0; ds[5] = 0;
      da[6] = 16'h8000; db[6] = 16'h0001; dc[6] = 0; ds[6] = 1;
      da[7] = 16'h8000; db[7] = 16'h8000; dc[7] = 1; ds[7] = 0;

      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++)
         issue(da[i], db[i], dc[i], ds[i]);
      drain(50);

      // backpressure with a competing request held
      rdy_mode = 0;
      issue(16'h1357, 16'h2468, 1'b0, 1'b0);
      t = 0;
      while (!out_valid) begin
         @(negedge clk);
         t = t + 1;
         if (t > 20) begin
            fail("bp_wait_valid");
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_a = 16'h4000;
      in_b = 16'h0FFF;
      in_cin = 1'b1;
      in_sub = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_valid", 32'(out_valid), 1);
         chk("bp_in_ready", 32'(in_ready), 0);
         if (q.size() == 0) begin
            fail("bp_queue");
         end else begin
            chk("bp_sum", 32'(out_sum), 32'(q[0].sum));
            chk("bp_cout", 32'(out_cout), 32'(q[0].cout));
            chk("bp_ovf", 32'(out_ovf), 32'(q[0].ovf));
         end
      end
      rdy_mode = 1;
      t = 0;
      do begin
         @(negedge clk);
         t = t + 1;
         if (t > 5) begin
            fail("bp_release");
            break;
         end
      end while (out_valid);
      chk("bp_idle_ready", 32'(in_ready), 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_new_accept", 32'(busy), 1);
      drain(50);

      // reset in RUN after two nibbles
      issue(16'hAAAA, 16'h5555, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("run_busy", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(out_valid), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_in_ready", 32'(in_ready), 1);
      q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("no_stale", 32'(out_valid), 0);
      end
      issue(16'h1111, 16'h2222, 1'b0, 1'b0);
      drain(50);

      // randomized traffic with random backpressure
      pick[0] = 16'h0000;
      pick[1] = 16'hFFFF;
      pick[2] = 16'h7FFF;
      pick[3] = 16'h8000;
      pick[4] = 16'h0001;
      rdy_mode = 2;
      for (int i = 0; i < 60; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if ($urandom_range(0, 3) == 0)
            ra = pick[$urandom_range(0, 4)];
         if ($urandom_range(0, 3) == 0)
            rb = pick[$urandom_range(0, 4)];
         issue(ra, rb, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      end
      drain(200);
      rdy_mode = 1;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-cycle wide adder/subtractor that time-shares a single instance of the team's 4-bit carry-lookahead adder (`cla`) across the nibbles of a WIDTH-bit operand pair. One nibble is processed per clock, least-significant first, with the ripple carry held in a register between cycles. The block is a sequencer and controller around the existing adder datapath. It has valid/ready handshakes on both sides so it can sit between a request source and a result consumer in the arithmetic path.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in, used only for add
- in_sub  in  1  0 = A+B+cin; 1 = A−B
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry out of bit WIDTH−1; for sub, 1 = no borrow
- out_ovf  out  1  two's-complement signed overflow
- busy  out  1  high whenever state ≠ IDLE

## Operation
- NIB = WIDTH/4. FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch the following and go to RUN:
    - a_r = in_a
    - b_r = in_sub ? ~in_b : in_b
    - c_r = in_sub ? 1 : in_cin
    - sub_r = in_sub
    - idx = 0
- RUN:
  - The `cla` inputs are a_r[4·idx+:4], b_r[4·idx+:4] and c_r.
  - Each edge writes the `cla` sum into sum_r[4·idx+:4], loads c_r with the `cla` carry, and increments idx.
  - When idx = NIB−1, the edge also goes to DONE.
  - in_ready = 0. in_valid is ignored.
- DONE:
  - out_valid = 1.
  - out_sum = sum_r and out_cout = c_r.
  - out_ovf = (a_r[W−1] == b_r[W−1]) & (sum_r[W−1] != a_r[W−1]).
  - On out_ready, go to IDLE.
  - in_ready = 0.
- Outputs are stable while out_valid & !out_ready.
- out_sum, out_cout and out_ovf reflect the register contents and are don't-care outside DONE.
- Results are modulo 2^WIDTH. No sign extension is applied.
- Reset:
  - State = IDLE; idx, c_r, a_r, b_r and sum_r are cleared to 0.
  - out_valid = 0, busy = 0, in_ready = 1.
- Reset asserted mid-RUN or mid-DONE aborts immediately. The partial result is discarded and no out_valid is produced for it.

## Timing
- The accept edge is E0. Nibble k is registered at edge E(k+1). out_valid rises after edge E_NIB.
- Latency is therefore NIB cycles from accept to out_valid. For WIDTH=16, out_valid is high in the 4th cycle after the accept edge.
- Minimum initiation interval is NIB+2 cycles: the accept edge, NIB RUN edges, and the DONE→IDLE edge.
- in_ready, out_valid and busy decode combinationally from the state register only. There is no combinational path from in_valid/out_ready to in_ready/out_valid.
- The `cla` path is purely combinational between registers, giving one 4-bit CLA delay per cycle.

## Structure
- Package `cla_seq_pkg` holds:
  - the state enum (IDLE, RUN, DONE)
  - a `NIB_W` helper function returning $clog2(WIDTH/4), floored at 1, for sizing idx
- The only sub-module is one instance of the existing 4-bit `cla` (ports a, b, cin, sum, carry). No other hierarchy.
- An elaboration-time check rejects WIDTH not divisible by 4, or WIDTH < 8.

## Test plan
All scenarios use WIDTH=16.
- 0x00FF + 0x0001, cin=0, add → sum 0x0100, cout 0, ovf 0. out_valid appears exactly 4 cycles after the accept edge.
- 0xFFFF + 0x0001, cin=0 → sum 0x0000, cout 1, ovf 0. Also 0x1234 + 0x0000 with cin=1 → 0x1235.
- Subtract 0x0005 − 0x0007 → sum 0xFFFE, cout 0 (borrow), ovf 0. Subtract 0x0007 − 0x0005 → 0x0002, cout 1.
- Overflow cases:
  - 0x7FFF + 0x0001 → sum 0x8000, ovf 1.
  - 0x8000 − 0x0001 → 0x7FFF, ovf 1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands → outputs unchanged and in_ready 0 throughout.
  - Release out_ready → IDLE next cycle, then the new op is accepted.
- Reset during RUN after 2 nibbles → out_valid/busy 0 and in_ready 1 immediately. No stale result appears. The following op 0x1111 + 0x2222 gives 0x3333.
